// File: rtl/multifunction_barrel_shifter_stage_reversal_if.sv
// Operand/result bundle for the bidirectional rotator stage.
// The master drives operands and consumes results; the slave is the rotator itself.
interface multifunction_barrel_shifter_stage_reversal_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic             dir;
  logic             out_valid;
  logic [WIDTH-1:0] y;

  modport master (output in_valid, a, amt, dir, input out_valid, y);
  modport slave  (input in_valid, a, amt, dir, output out_valid, y);
endinterface

// File: rtl/multifunction_barrel_shifter_stage_reversal.sv
// Registered bidirectional rotator: one right-rotate barrel core, with optional bit
// reversal on both sides so that the same core also produces left rotations.
module multifunction_barrel_shifter_stage_reversal #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  multifunction_barrel_shifter_stage_reversal_if.slave bus
);

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  logic [WIDTH-1:0] stage [0:AMT_W];
  logic [WIDTH-1:0] r;

  // Reversing, rotating right, then reversing back is a left rotation by the same amount.
  assign stage[0] = bus.dir ? bitrev(bus.a) : bus.a;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stage[k+1] = bus.amt[k] ? {stage[k][SH-1:0], stage[k][WIDTH-1:SH]}
                                   : stage[k];
  end

  assign r = bus.dir ? bitrev(stage[AMT_W]) : stage[AMT_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.y         <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.y <= r;
    end
  end

endmodule

// File: tb/tb_multifunction_barrel_shifter_stage_reversal.sv
// Scoreboard bench for the bidirectional rotator: directed vectors, reset/hold behaviour,
// and an exhaustive back-to-back sweep with left rotations predicted as right rotations by WIDTH-k.
module tb_multifunction_barrel_shifter_stage_reversal;
  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic clk;
  logic rst_n;

  multifunction_barrel_shifter_stage_reversal_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  multifunction_barrel_shifter_stage_reversal #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] y;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] model_y = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ror_ref(input logic [WIDTH-1:0] x, input int n);
    logic [2*WIDTH-1:0] d;
    d = {x, x} >> n;
    return d[WIDTH-1:0];
  endfunction

  // Drive one cycle's inputs and push what the following edge must produce.
  task automatic cycle(input logic rst, input logic v, input logic [WIDTH-1:0] a,
                       input int amt, input logic dir, input logic [WIDTH-1:0] exp_y,
                       input string tag);
    exp_t e;
    rst_n        = rst;
    bus.in_valid = v;
    bus.a        = a;
    bus.amt      = AMT_W'(amt);
    bus.dir      = dir;
    if (!rst)   model_y = '0;
    else if (v) model_y = exp_y;
    e.v   = rst & v;
    e.y   = model_y;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rot_ref(input logic [WIDTH-1:0] x, input int k,
                                               input logic dir);
    return dir ? ror_ref(x, (WIDTH - k) % WIDTH) : ror_ref(x, k);
  endfunction

  // Results of edge N are sampled on the falling edge that follows it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, "_valid"}, 32'(bus.out_valid), 32'(e.v));
        check({e.tag, "_y"}, 32'(bus.y), 32'(e.y));
      end
    end
  end

  initial begin
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.a = '0; bus.amt = '0; bus.dir = 1'b0;
    cycle(1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, "reset");
    cycle(1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, "reset2");

    cycle(1'b1, 1'b1, 8'b10001100, 4, 1'b1, 8'b11001000, "v1_rol4");
    cycle(1'b1, 1'b1, 8'b10101010, 0, 1'b0, 8'b10101010, "v2_ident");
    cycle(1'b1, 1'b1, 8'b01010101, 6, 1'b0, 8'b01010101, "v2_ror6");
    cycle(1'b1, 1'b1, 8'b10010110, 5, 1'b1, 8'b11010010, "v3_rol5");
    cycle(1'b1, 1'b1, 8'b11010101, 3, 1'b1, 8'b10101110, "v3_rol3");
    cycle(1'b1, 1'b1, 8'b10110011, 2, 1'b0, 8'b11101100, "v4_ror2");
    cycle(1'b1, 1'b1, 8'b11001111, 5, 1'b0, 8'b01111110, "v4_ror5");
    cycle(1'b1, 1'b1, 8'b10000001, 0, 1'b1, 8'b10000001, "rol0_ident");
    cycle(1'b1, 1'b0, 8'h5A, 3, 1'b1, 8'h00, "hold_nonzero");

    cycle(1'b0, 1'b1, 8'hFF, 1, 1'b1, 8'h00, "rst_wins");
    cycle(1'b1, 1'b0, 8'hFF, 1, 1'b1, 8'h00, "post_rst_hold");

    for (int d = 0; d < 2; d++)
      for (int k = 0; k < WIDTH; k++)
        for (int x = 0; x < 256; x++)
          cycle(1'b1, 1'b1, WIDTH'(x), k, d[0], rot_ref(WIDTH'(x), k, d[0]), "sweep");

    cycle(1'b1, 1'b0, 8'h00, 0, 1'b0, 8'h00, "tail_idle");
    repeat (2) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
